// File: rtl/melody_step_sequencer.sv
// melody_step_sequencer
//   Tempo-driven step sequencer that produces the step index for the note mux.
//   It walks steps 0..LAST_STEP at one step per TICKS_PER_STEP clocks, either
//   ascending or descending. It can pause, restart, loop, or stop after one
//   pass. When a one-shot pass ends it parks on step 0, the silence slot.
//
// Ports
//   clk, rst_n  : clock; asynchronous active-low reset
//   start       : one-cycle pulse, (re)start from the first step (highest priority)
//   activado    : 1 = run, 0 = pause (position and tempo count held)
//   updown      : 1 = ascending, 0 = descending
//   loop_en     : 1 = wrap at the end of the melody, 0 = stop at the end
//   sel         : registered step index
//   playing     : high while in PLAY
//   step_tick   : one-cycle pulse on every step advance, including a wrap
//   done        : one-cycle pulse when a one-shot melody ends
module melody_step_sequencer #(
    parameter int TICKS_PER_STEP = 12_500_000,
    parameter int LAST_STEP      = 20,
    parameter int STEP_W         = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              activado,
    input  logic              updown,
    input  logic              loop_en,
    output logic [STEP_W-1:0] sel,
    output logic              playing,
    output logic              step_tick,
    output logic              done
);

    // Tempo counter width. It is at least one bit so that TICKS_PER_STEP=1 still builds.
    localparam int CW = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;

    localparam logic [CW-1:0]     CNT_MAX  = CW'(TICKS_PER_STEP - 1);
    localparam logic [CW-1:0]     CNT_ONE  = CW'(1);
    localparam logic [STEP_W-1:0] STEP_TOP = STEP_W'(LAST_STEP);
    localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state, state_nx;
    logic [STEP_W-1:0] sel_nx;
    logic [CW-1:0]     cnt, cnt_nx;
    logic              tick_nx, done_nx;

    logic              boundary;
    logic              at_last;
    logic [STEP_W-1:0] first_step;

    // The first step and the last-step test both use the direction that is
    // sampled in the current cycle. A mid-step flip therefore only redirects the next advance.
    assign first_step = updown ? '0 : STEP_TOP;
    assign at_last    = updown ? (sel == STEP_TOP) : (sel == '0);
    assign boundary   = (cnt == CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sel       <= '0;
            cnt       <= '0;
            step_tick <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nx;
            sel       <= sel_nx;
            cnt       <= cnt_nx;
            step_tick <= tick_nx;
            done      <= done_nx;
        end
    end

    always_comb begin
        state_nx = state;
        sel_nx   = sel;
        cnt_nx   = cnt;
        tick_nx  = 1'b0;
        done_nx  = 1'b0;

        if (start) begin
            // A restart overrides everything, including a coincident boundary.
            // No pulse is issued in this cycle.
            state_nx = PLAY;
            sel_nx   = first_step;
            cnt_nx   = '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    sel_nx = '0;
                    cnt_nx = '0;
                end
                PLAY: begin
                    if (activado) begin
                        if (boundary) begin
                            cnt_nx = '0;
                            if (!at_last) begin
                                // at_last guards both ends, so this step never wraps the register.
                                sel_nx  = updown ? (sel + STEP_ONE) : (sel - STEP_ONE);
                                tick_nx = 1'b1;
                            end else if (loop_en) begin
                                sel_nx  = first_step;
                                tick_nx = 1'b1;
                            end else begin
                                state_nx = DONE;
                                sel_nx   = '0;
                                done_nx  = 1'b1;
                            end
                        end else begin
                            cnt_nx = cnt + CNT_ONE;
                        end
                    end
                end
                default: begin
                    state_nx = IDLE;
                    sel_nx   = '0;
                    cnt_nx   = '0;
                end
            endcase
        end
    end

    assign playing = (state == PLAY);

endmodule
